// File: rtl/dbgu_cmd_engine_if.sv
// Signal bundle between the debug command engine and its environment:
// UART rx byte stream, tx response handshake, memory request port and status.
interface dbgu_cmd_engine_if #(
    parameter int DW = 32,
    parameter int AW = 32
) ();
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            mem_req;
    logic [DW/8-1:0] mem_we;
    logic [AW-1:0]   mem_adr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic            cpu_reset;
    logic            busy;
    logic            err_overrun;

    // Engine side: consumes rx bytes and memory responses, drives everything else.
    modport master (
        input  rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        output tx_data, tx_valid, mem_req, mem_we, mem_adr, mem_wdata,
               cpu_reset, busy, err_overrun
    );

    // Environment side: UART, memory and CPU-control observer.
    modport slave (
        output rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        input  tx_data, tx_valid, mem_req, mem_we, mem_adr, mem_wdata,
               cpu_reset, busy, err_overrun
    );
endinterface

// File: rtl/dbgu_cmd_engine.sv
// dbgu_cmd_engine: byte-oriented debug command engine. Decodes commands from
// a UART byte stream, runs word bursts on a simple memory port and returns
// read data or status bytes on a valid/ready tx channel.
module dbgu_cmd_engine #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int CW     = 8,
    parameter int TO_CYC = 100000
) (
    input logic               clk,
    input logic               reset,
    dbgu_cmd_engine_if.master bus
);
    localparam int NB   = DW / 8;
    localparam int NA   = AW / 8;
    localparam int CB   = (CW / 8 < 1) ? 1 : CW / 8;
    localparam int ARGB = (NA > CB) ? NA : CB;
    localparam int ARGW = 8 * ARGB;
    localparam int TW   = $clog2(TO_CYC + 1);

    localparam logic [7:0]    NB_LAST = 8'(NB - 1);
    localparam logic [7:0]    NA_LAST = 8'(NA - 1);
    localparam logic [7:0]    CB_LAST = 8'(CB - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_SET_CNT  = 8'h02;
    localparam logic [7:0] CMD_CPU_RST  = 8'h03;
    localparam logic [7:0] CMD_WRITE    = 8'h04;
    localparam logic [7:0] CMD_READ     = 8'h05;
    localparam logic [7:0] CMD_PING     = 8'h06;

    typedef enum logic [2:0] {IDLE, ARG, WDATA, MEMW, MEMR, TXW, TX1} state_t;

    state_t          state;
    logic [7:0]      cmd;         // command whose arguments are being collected
    logic [7:0]      idx;         // byte index within the current argument or word
    logic [ARGW-1:0] arg_buf;     // little-endian argument bytes, newest at the top
    logic [DW-1:0]   wbuf;        // write word being assembled
    logic [DW-1:0]   rbuf;        // read word bytes still to be transmitted
    logic [AW-1:0]   addr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   burst_left;  // words remaining after the current one
    logic [TW-1:0]   to_cnt;      // idle cycles since the last rx byte

    logic [7:0]      arg_last;
    logic [ARGW+7:0] arg_cat;
    logic [ARGW-1:0] arg_next;
    logic [DW+7:0]   w_cat;
    logic [DW-1:0]   wnext;
    logic            to_expire;

    // Next-value helpers: argument/word shift-in and timeout detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        arg_last = 8'd0;
        case (cmd)
            CMD_SET_ADDR: arg_last = NA_LAST;
            CMD_SET_CNT:  arg_last = CB_LAST;
            default:      arg_last = 8'd0;
        endcase
        arg_cat   = {bus.rx_data, arg_buf} >> 8;
        arg_next  = arg_cat[ARGW-1:0];
        w_cat     = {bus.rx_data, wbuf} >> 8;
        wnext     = w_cat[DW-1:0];
        to_expire = !bus.rx_valid && (to_cnt == TO_LAST);
    end

    assign bus.busy = (state != IDLE);

    // Command FSM with registered memory, tx and status outputs.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state           <= IDLE;
            cmd             <= '0;
            idx             <= '0;
            arg_buf         <= '0;
            wbuf            <= '0;
            rbuf            <= '0;
            addr            <= '0;
            count           <= '0;
            burst_left      <= '0;
            to_cnt          <= '0;
            bus.cpu_reset   <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= '0;
            bus.mem_adr     <= '0;
            bus.mem_wdata   <= '0;
            bus.tx_valid    <= 1'b0;
            bus.tx_data     <= '0;
            bus.err_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        cmd    <= bus.rx_data;
                        idx    <= '0;
                        to_cnt <= '0;
                        case (bus.rx_data)
                            CMD_SET_ADDR, CMD_SET_CNT, CMD_CPU_RST: state <= ARG;
                            CMD_WRITE: begin
                                burst_left <= count;
                                state      <= WDATA;
                            end
                            CMD_READ: begin
                                burst_left  <= count;
                                bus.mem_req <= 1'b1;
                                bus.mem_we  <= '0;
                                bus.mem_adr <= addr;
                                state       <= MEMR;
                            end
                            CMD_PING: begin
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= 8'hA5;
                                state        <= TX1;
                            end
                            default: begin
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= 8'hEE;
                                state        <= TX1;
                            end
                        endcase
                    end
                end
                ARG: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (bus.rx_valid) begin
                        to_cnt  <= '0;
                        arg_buf <= arg_next;
                        idx     <= idx + 8'd1;
                        if (idx == arg_last) begin
                            case (cmd)
                                CMD_SET_ADDR: addr          <= AW'(arg_next >> (ARGW - AW));
                                CMD_SET_CNT:  count         <= CW'(arg_next >> (ARGW - 8 * CB));
                                default:      bus.cpu_reset <= bus.rx_data[0];
                            endcase
                            state <= IDLE;
                        end
                    end else if (to_expire) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WDATA: begin
                    if (bus.rx_valid) begin
                        to_cnt <= '0;
                        wbuf   <= wnext;
                        if (idx == NB_LAST) begin
                            idx           <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= '1;
                            bus.mem_adr   <= addr;
                            bus.mem_wdata <= wnext;
                            state         <= MEMW;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else if (to_expire) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                MEMW: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= '0;
                        addr        <= addr + AW'(NB);
                        if (burst_left == '0) begin
                            state <= IDLE;
                        end else begin
                            burst_left <= burst_left - 1'b1;
                            to_cnt     <= '0;
                            state      <= WDATA;
                        end
                    end
                end
                MEMR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req  <= 1'b0;
                        addr         <= addr + AW'(NB);
                        rbuf         <= bus.mem_rdata >> 8;
                        bus.tx_data  <= bus.mem_rdata[7:0];
                        bus.tx_valid <= 1'b1;
                        idx          <= '0;
                        state        <= TXW;
                    end
                end
                TXW: begin
                    if (bus.tx_ready) begin
                        if (idx == NB_LAST) begin
                            bus.tx_valid <= 1'b0;
                            if (burst_left == '0) begin
                                state <= IDLE;
                            end else begin
                                burst_left  <= burst_left - 1'b1;
                                bus.mem_req <= 1'b1;
                                bus.mem_we  <= '0;
                                bus.mem_adr <= addr;
                                state       <= MEMR;
                            end
                        end else begin
                            idx         <= idx + 8'd1;
                            bus.tx_data <= rbuf[7:0];
                            rbuf        <= rbuf >> 8;
                        end
                    end
                end
                TX1: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Bytes arriving while the engine is busy on memory or tx are lost.
            if (bus.rx_valid && (state inside {MEMW, MEMR, TXW, TX1})) begin
                bus.err_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: doc/dbgu_cmd_engine.md
DBGU_CMD_ENGINE -- requirements
Module: dbgu_cmd_engine

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset are fixed.
REQ-002 SHALL have parameter DW, default 32: memory data width in bits, a multiple of 8 (NB = DW/8 bytes).
REQ-003 SHALL have parameter AW, default 32: address width in bits, a multiple of 8 (NA = AW/8 bytes).
REQ-004 SHALL have parameter CW, default 8: burst count width in bits.
REQ-005 SHALL have parameter TO_CYC, default 100000: inter-byte timeout in clk cycles.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have ports rx_data (input, 8) and rx_valid (input, 1): received UART byte and its one-cycle strobe.
REQ-009 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1): response byte with valid/ready handshake.
REQ-010 SHALL have ports mem_req (output, 1), mem_we (output, NB), mem_adr (output, AW) and mem_wdata (output, DW): memory request; mem_we is all-ones for a write and zero for a read.
REQ-011 SHALL have ports mem_rdata (input, DW) and mem_ack (input, 1): read data and one-cycle completion strobe.
REQ-012 SHALL have ports cpu_reset (output, 1), busy (output, 1) and err_overrun (output, 1): CPU hold, engine not idle, and sticky dropped-byte flag.

Function
REQ-013 SHALL accept one command byte in IDLE; every multi-byte field is little-endian.
REQ-014 SHALL implement 0x01 SET_ADDR: NA argument bytes; the address register is loaded only after the last byte arrives.
REQ-015 SHALL implement 0x02 SET_CNT: CW/8 (minimum 1) argument bytes loaded into the count register; a burst transfers count+1 words.
REQ-016 SHALL implement 0x03 CPU_RST: 1 argument byte; cpu_reset is set to bit 0 of that byte.
REQ-017 SHALL implement 0x04 WRITE: count+1 words of NB bytes each; the cycle after a word's last byte, mem_req=1, mem_we=all-ones, mem_adr=addr, mem_wdata=assembled word.
REQ-018 SHALL implement 0x05 READ: mem_req=1, mem_we=0 the cycle after the command byte; mem_rdata is latched on mem_ack; tx_valid is asserted the next cycle with byte 0, and bytes 1..NB-1 follow, one per tx_valid&&tx_ready; then the next word is requested, count+1 words in total.
REQ-019 SHALL implement 0x06 PING: transmit the single byte 0xA5.
REQ-020 SHALL, on any other command byte, transmit the single byte 0xEE and return to IDLE.
REQ-021 SHALL hold mem_req, mem_adr, mem_we and mem_wdata stable until mem_ack, and deassert mem_req in the cycle following mem_ack.
REQ-022 SHALL add NB to addr after each mem_ack, wrapping modulo 2^AW; the count register itself is not modified by bursts.
REQ-023 SHALL hold tx_data stable while tx_valid=1 && tx_ready=0.
REQ-024 SHALL use states IDLE, ARG, WDATA, MEMW, MEMR, TXW and TX1; busy=1 in every state except IDLE.
REQ-025 SHALL drop any rx_valid byte arriving in MEMW, MEMR, TXW or TX1, and set err_overrun=1 (sticky).
REQ-026 SHALL treat a gap of TO_CYC cycles without rx_valid in ARG or WDATA as a timeout: return to IDLE, discard partial bytes, leave addr, count and cpu_reset unchanged, transmit nothing, and keep any words already written.
REQ-027 SHALL, when rx_valid and timeout expiry coincide, take the byte and restart the timeout counter.

Reset
REQ-028 SHALL, on reset=1 at a clk edge, set: state=IDLE, addr=0, count=0, cpu_reset=0, mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0, tx_valid=0, tx_data=0, busy=0, err_overrun=0.
REQ-029 SHALL let reset asserted mid-transfer abort immediately; mem_req drops the next cycle regardless of mem_ack.

Verification (DW=32, AW=32, CW=8)
REQ-030 SHALL pass: bytes 01 20 00 00 00, 04 DD CC BB AA -> one request: mem_adr=0x00000020, mem_wdata=0xAABBCCDD, mem_we=0xF; after ack, addr=0x24.
REQ-031 SHALL pass: 01 20 00 00 00, 05, memory returns 0xAABBCCDD -> tx bytes DD CC BB AA in order, with tx_ready toggling every other cycle and tx_data stable while stalled.
REQ-032 SHALL pass: 02 01, 01 FC FF FF FF, 04 plus 8 data bytes -> writes to 0xFFFFFFFC then 0x00000000 (wrap).
REQ-033 SHALL pass: 01 12 34 then silence for TO_CYC cycles -> IDLE, addr unchanged, no tx; then 06 -> tx A5.
REQ-034 SHALL pass: 05 with mem_ack delayed 10 cycles and rx byte 0x77 injected meanwhile -> err_overrun=1, 0x77 ignored, read completes normally.
REQ-035 SHALL pass: 03 01 -> cpu_reset=1; byte 0x99 -> tx EE; 03 00 -> cpu_reset=0; reset mid-READ -> all outputs at reset values the next cycle.
